// File: rtl/serial_link_sched.sv
// Round-robin scheduler sharing one serial link between two parallel-word requesters.
// Words are serialized MSB-first with shift enable and frame marker, followed by an idle gap.
module serial_link_sched #(
    parameter int WIDTH = 6,
    parameter int GAP   = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_a_valid,
    input  logic [WIDTH-1:0] i_a_data,
    output logic             o_a_ready,
    input  logic             i_b_valid,
    input  logic [WIDTH-1:0] i_b_data,
    output logic             o_b_ready,
    output logic             o_sdout,
    output logic             o_sen,
    output logic             o_sframe,
    output logic             o_grant_id,
    output logic             o_busy,
    output logic             o_done
);
    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);
    localparam logic [3:0]    GAP_LOAD = (GAP > 0) ? 4'(GAP - 1) : 4'd0;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_GAP   = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [WIDTH-1:0] r_buf;
    logic [CW-1:0]    r_cnt;
    logic [3:0]       r_gap_cnt;
    logic             r_last_grant;
    logic             r_grant_id;
    logic             r_done;
    logic             w_grant;
    logic             w_take;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        // On a tie the requester not served last wins; otherwise whichever is valid.
        w_grant     = (i_a_valid && i_b_valid) ? ~r_last_grant : i_b_valid;
        w_take      = 1'b0;
        o_a_ready   = 1'b0;
        o_b_ready   = 1'b0;
        o_sen       = 1'b0;
        o_sdout     = 1'b0;
        o_sframe    = 1'b0;
        o_busy      = 1'b1;
        case (r_state)
            S_IDLE: begin
                o_busy    = 1'b0;
                w_take    = (i_a_valid || i_b_valid) && !rst;
                o_a_ready = w_take && !w_grant;
                o_b_ready = w_take && w_grant;
                if (w_take) begin
                    w_state_nxt = S_SHIFT;
                end
            end
            S_SHIFT: begin
                o_sen    = 1'b1;
                o_sdout  = r_buf[WIDTH-1];
                o_sframe = (r_cnt == '0);
                if (r_cnt == CNT_LAST) begin
                    w_state_nxt = (GAP > 0) ? S_GAP : S_IDLE;
                end
            end
            S_GAP: begin
                if (r_gap_cnt == 4'd0) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                o_busy      = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_buf        <= '0;
            r_cnt        <= '0;
            r_gap_cnt    <= 4'd0;
            r_last_grant <= 1'b1;
            r_grant_id   <= 1'b0;
            r_done       <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_take) begin
                        r_buf        <= w_grant ? i_b_data : i_a_data;
                        r_grant_id   <= w_grant;
                        r_last_grant <= w_grant;
                        r_cnt        <= '0;
                    end
                end
                S_SHIFT: begin
                    r_buf <= r_buf << 1;
                    if (r_cnt == CNT_LAST) begin
                        r_done    <= 1'b1;
                        r_gap_cnt <= GAP_LOAD;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_GAP: begin
                    if (r_gap_cnt != 4'd0) begin
                        r_gap_cnt <= r_gap_cnt - 4'd1;
                    end
                end
                default: begin
                    r_cnt <= '0;
                end
            endcase
        end
    end

    assign o_grant_id = r_grant_id;
    assign o_done     = r_done;
endmodule

// File: tb/tb_serial_link_sched.sv
// Bench for serial_link_sched: GAP=1 and GAP=0 instances checked every cycle against a
// timeline model (handshake cycle, frame window, next-free cycle) plus a downstream chain.
module tb_serial_link_sched;
    localparam int W = 6;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                rst;
    logic [3:0]          vld;
    logic [3:0][W-1:0]   dat;
    logic [1:0]          ra, rb, sdo, sen, sfr, gid, bsy, dn;
    logic [1:0][W-1:0]   chain;

    // stimulus shadow, applied to the DUT only at the falling edge
    logic                s_rst;
    logic [3:0]          s_vld;
    logic [3:0][W-1:0]   s_dat;
    logic                rnd;
    logic [W-1:0]        srcq [4][$];

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    int           m_start [2];
    int           m_free  [2];
    logic         m_last  [2];
    logic         m_gid   [2];
    logic [W-1:0] m_word  [2];

    serial_link_sched #(.WIDTH(W), .GAP(1)) u_dut_g1 (
        .clk(clk), .rst(rst),
        .i_a_valid(vld[0]), .i_a_data(dat[0]), .o_a_ready(ra[0]),
        .i_b_valid(vld[1]), .i_b_data(dat[1]), .o_b_ready(rb[0]),
        .o_sdout(sdo[0]), .o_sen(sen[0]), .o_sframe(sfr[0]),
        .o_grant_id(gid[0]), .o_busy(bsy[0]), .o_done(dn[0])
    );

    serial_link_sched #(.WIDTH(W), .GAP(0)) u_dut_g0 (
        .clk(clk), .rst(rst),
        .i_a_valid(vld[2]), .i_a_data(dat[2]), .o_a_ready(ra[1]),
        .i_b_valid(vld[3]), .i_b_data(dat[3]), .o_b_ready(rb[1]),
        .o_sdout(sdo[1]), .o_sen(sen[1]), .o_sframe(sfr[1]),
        .o_grant_id(gid[1]), .o_busy(bsy[1]), .o_done(dn[1])
    );

    // downstream 6-stage shift chain fed by each link
    always @(posedge clk) begin
        if (sen[0]) chain[0] <= {chain[0][W-2:0], sdo[0]};
        if (sen[1]) chain[1] <= {chain[1][W-2:0], sdo[1]};
    end

    task automatic chk(input string tag, input int d, input logic [W-1:0] obs, input logic [W-1:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s dut%0d cyc=%0d observed=%0h expected=%0h", tag, d, cyc, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            m_start[d] = -100;
            m_free[d]  = cyc + 1;
            m_last[d]  = 1'b1;
            m_gid[d]   = 1'b0;
        end
    endtask

    task automatic check_and_commit(input int d);
        int   g, off;
        logic e_sen, e_sdo, e_sfr, e_dn, e_bsy, e_ra, e_rb, e_gid, grant, av, bv;
        g     = (d == 0) ? 1 : 0;
        off   = cyc - m_start[d];
        av    = vld[d*2];
        bv    = vld[d*2+1];
        grant = (av && bv) ? !m_last[d] : bv;
        if (rst) begin
            {e_sen, e_sdo, e_sfr, e_dn, e_bsy, e_ra, e_rb, e_gid} = '0;
        end else begin
            e_sen = (off >= 1) && (off <= W);
            e_sdo = e_sen ? m_word[d][W-off] : 1'b0;
            e_sfr = (off == 1);
            e_dn  = (off == W + 1);
            e_bsy = (off >= 1) && (off <= W + g);
            e_ra  = (cyc >= m_free[d]) && av && !grant;
            e_rb  = (cyc >= m_free[d]) && bv && grant;
            e_gid = m_gid[d];
        end
        chk("a_ready",    d, ra[d],  e_ra);
        chk("b_ready",    d, rb[d],  e_rb);
        chk("one_ready",  d, ra[d] & rb[d], 1'b0);
        chk("sen",        d, sen[d], e_sen);
        chk("sdout",      d, sdo[d], e_sdo);
        chk("sframe",     d, sfr[d], e_sfr);
        chk("done",       d, dn[d],  e_dn);
        chk("busy",       d, bsy[d], e_bsy);
        chk("grant_id",   d, gid[d], e_gid);
        if (e_dn) chk("chain_q", d, chain[d], m_word[d]);

        if (!rst && (e_ra || e_rb)) begin
            m_start[d] = cyc;
            m_word[d]  = e_rb ? dat[d*2+1] : dat[d*2];
            m_gid[d]   = e_rb;
            m_last[d]  = e_rb;
            m_free[d]  = cyc + W + g + 1;
        end
        if (ra[d]) s_vld[d*2]   = 1'b0;
        if (rb[d]) s_vld[d*2+1] = 1'b0;
    endtask

    task automatic one_cycle();
        @(negedge clk);
        if (rnd) s_rst = ($urandom_range(0, 299) == 0);
        for (int i = 0; i < 4; i++) begin
            if (rnd && !s_vld[i] && $urandom_range(0, 2) == 0) srcq[i].push_back(W'($urandom));
            if (!s_vld[i] && srcq[i].size() > 0) begin
                s_vld[i] = 1'b1;
                s_dat[i] = srcq[i].pop_front();
            end else if (rnd && s_vld[i] && $urandom_range(0, 15) == 0) begin
                s_vld[i] = 1'b0;
            end
        end
        rst = s_rst;
        vld = s_vld;
        dat = s_dat;
        #1;
        if (rst) begin
            check_and_commit(0);
            check_and_commit(1);
            model_reset();
        end else begin
            check_and_commit(0);
            check_and_commit(1);
        end
        cyc++;
    endtask

    task automatic step(input int n);
        for (int i = 0; i < n; i++) one_cycle();
    endtask

    initial begin
        rnd   = 1'b0;
        s_rst = 1'b1;
        s_vld = '0;
        s_dat = '0;
        rst   = 1'b1;
        vld   = '0;
        dat   = '0;
        chain = '0;
        model_reset();
        step(3);
        s_rst = 1'b0;
        step(2);

        // single A word
        srcq[0].push_back(6'b101101);
        srcq[2].push_back(6'b101101);
        step(14);

        // both requesters under continuous demand
        for (int i = 0; i < 5; i++) begin
            srcq[0].push_back(6'h2A); srcq[2].push_back(6'h2A);
            srcq[1].push_back(6'h15); srcq[3].push_back(6'h15);
        end
        step(90);

        // only B, three words
        foreach (srcq[i]) srcq[i].delete();
        srcq[1].push_back(6'h3F); srcq[1].push_back(6'h00); srcq[1].push_back(6'h21);
        srcq[3].push_back(6'h3F); srcq[3].push_back(6'h00); srcq[3].push_back(6'h21);
        step(30);

        // reset in cycle k+3 of an A frame, then a tie must go to A
        srcq[0].push_back(6'h1B);
        srcq[2].push_back(6'h1B);
        step(3);
        s_rst = 1'b1;
        step(2);
        s_rst = 1'b0;
        for (int i = 0; i < 4; i++) srcq[i].push_back(W'($urandom));
        step(25);

        // B raises valid during an A frame and withdraws it before being served
        srcq[0].push_back(6'h33);
        srcq[2].push_back(6'h33);
        step(1);
        s_vld[1] = 1'b1; s_dat[1] = 6'h0C;
        s_vld[3] = 1'b1; s_dat[3] = 6'h0C;
        step(5);
        s_vld[3] = 1'b0;
        step(1);
        s_vld[1] = 1'b0;
        step(12);

        // randomized traffic with occasional withdrawals and resets
        rnd = 1'b1;
        step(600);
        rnd   = 1'b0;
        s_rst = 1'b0;
        s_vld = '0;
        foreach (srcq[i]) srcq[i].delete();
        step(20);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/serial_link_sched.md
# serial_link_sched

Round-robin scheduler that shares one serial link, feeding a WIDTH-stage serial-in/parallel-out shift chain, between two parallel-word requesters. It accepts one word at a time through a valid/ready handshake, serializes it MSB-first with a shift enable and frame marker, then enforces an inter-frame gap. It sits between the producer-side blocks and the shared 6-stage shift-register datapath.

## Interface
- WIDTH, 6, bits per frame (≥2); equals the downstream chain depth
- GAP, 1, idle cycles after each frame before the next grant (0..15)

- clk  in  1  clock, all state on rising edge
- rst  in  1  reset, asynchronous, active-high
- a_valid  in  1  requester A has a word
- a_data  in  WIDTH  requester A word
- a_ready  out  1  A word accepted this cycle
- b_valid  in  1  requester B has a word
- b_data  in  WIDTH  requester B word
- b_ready  out  1  B word accepted this cycle
- sdout  out  1  serial data to chain input
- sen  out  1  shift enable; chain shifts on edges where sen=1
- sframe  out  1  high with the first (MSB) bit of a frame
- grant_id  out  1  source of current/last frame (0=A, 1=B)
- busy  out  1  high in any state other than IDLE
- done  out  1  one-cycle pulse after the last bit

## Operation
- States: IDLE, SHIFT, GAP.
- IDLE: grant computed combinationally. Only one valid → that one. Both valid → the one not granted last (last_grant register). x_ready = (state==IDLE) & grant==x & x_valid & !rst; at most one ready high.
- Transfer on rising edge with x_valid & x_ready: buf ← x_data, grant_id ← x, last_grant ← x, cnt ← 0, state → SHIFT.
- SHIFT: sen=1, sdout=buf[WIDTH-1], sframe=(cnt==0). Each edge: buf ← buf<<1, cnt ← cnt+1. On edge with cnt==WIDTH-1: state → GAP if GAP>0 else IDLE; done registered high for the following cycle.
- GAP: sen=0, sdout=0, gap counter runs GAP cycles, then → IDLE.
- Requesters hold valid and data stable until ready; valid dropped without ready has no effect. Data changes outside the handshake edge are ignored.
- cnt width clog2(WIDTH); no wrap beyond WIDTH-1.
- Reset (any time, incl. mid-frame): state IDLE, buf 0, cnt 0, gap counter 0, last_grant=B (A wins first tie), grant_id 0, sdout 0, sen 0, sframe 0, done 0, busy 0, ready 0. Aborted frame produces no done; the chain contents are not cleared by this block.

## Timing
- Handshake at edge k → bits MSB..LSB on sdout in cycles k+1..k+WIDTH with sen=1; sframe only in k+1.
- done high in cycle k+WIDTH+1 only; busy high cycles k+1 through the end of GAP.
- After the edge ending cycle k+WIDTH, the downstream chain holds the word: q[WIDTH-1:0] = word.
- Earliest next handshake: edge ending cycle k+WIDTH+GAP+1 (IDLE for one cycle); frame period WIDTH+GAP+1 cycles under continuous demand.
- GAP=0: done cycle is an IDLE cycle and a new grant may handshake in that same cycle.
- New valid arriving during SHIFT/GAP waits; no preemption.

## Test plan
- Reset then single A word 6'b101101, GAP=1: sdout 1,0,1,1,0,1 on cycles k+1..k+6, sframe only k+1, done at k+7, chain q=6'b101101, grant_id=0.
- A and B both valid continuously (A=6'h2A, B=6'h15): frames alternate A,B,A,B starting with A; frame starts exactly 8 cycles apart; never both ready.
- Only B valid for three words 6'h3F, 6'h00, 6'h21: B served back-to-back, grant_id=1, busy drops one cycle between frames.
- Assert rst at cycle k+3 of a frame: sen, sdout, busy, ready drop to 0 immediately; no done; next tie goes to A.
- GAP=0, both valid: handshake occurs in the done cycle; period 7 cycles.
- Requester drops valid before ready (B valid while A frame in flight, released during GAP): no B frame, no B ready, state returns to IDLE.
